// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: sequential radix-2 restoring divider, one quotient bit per clock.
// The operand width N matches the neighbouring Wallace-tree multiplier.
// Handshake: start (sampled in IDLE) -> busy while iterating -> one-cycle done pulse.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands and results.
// In that build the core still divides magnitudes, and the signs are applied when the
// results are registered.
module seq_restoring_divider #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] count_r;
    logic [N-1:0]  q_r;        // dividend shifts out of the top while quotient bits enter at the bottom
    logic [N:0]    r_r;        // partial remainder, one bit wider so the shift never overflows
    logic [N-1:0]  d_r;        // captured divisor (magnitude in the signed build)
    logic [N-1:0]  dvd_r;      // captured dividend as presented, returned as remainder on divide-by-zero

    logic [N:0]    r_shift_s;
    logic [N:0]    r_sub_s;
    logic          ge_s;
    logic [N-1:0]  q_shift_s;
    logic [N-1:0]  q_res_s;
    logic [N-1:0]  r_res_s;
    logic          dz_s;

`ifdef DIV_SIGNED_EN
    logic          q_neg_r;
    logic          r_neg_r;

    // Two's-complement magnitude; -2^(N-1) maps to 2^(N-1), which fits unsigned in N bits
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
        logic [N-1:0] m;
        if (v[N-1]) begin
            m = ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Conditional two's-complement negation used when applying result signs
    function automatic logic [N-1:0] apply_sign(input logic [N-1:0] v, input logic neg);
        logic [N-1:0] s;
        if (neg) begin
            s = ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            s = v;
        end
        return s;
    endfunction
`else
    // Unsigned build: operands enter the core unchanged
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
        return v;
    endfunction
`endif

    // One restoring step: shift the next dividend bit into R, then trial-subtract D
    always_comb begin
        r_shift_s = {r_r[N-1:0], q_r[N-1]};
        r_sub_s   = r_shift_s - {1'b0, d_r};
        ge_s      = (r_shift_s >= {1'b0, d_r});
        q_shift_s = {q_r[N-2:0], ge_s};
    end

    // Final result selection, including divide-by-zero and (optionally) sign fix-up
    always_comb begin
        dz_s = (d_r == {N{1'b0}});
        if (dz_s) begin
            q_res_s = {N{1'b1}};
            r_res_s = dvd_r;
        end else begin
`ifdef DIV_SIGNED_EN
            q_res_s = apply_sign(q_r, q_neg_r);
            r_res_s = apply_sign(r_r[N-1:0], r_neg_r);
`else
            q_res_s = q_r;
            r_res_s = r_r[N-1:0];
`endif
        end
    end

    // Control FSM, iteration datapath and registered handshake/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            q_r         <= {N{1'b0}};
            r_r         <= {(N+1){1'b0}};
            d_r         <= {N{1'b0}};
            dvd_r       <= {N{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {N{1'b0}};
            remainder   <= {N{1'b0}};
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_r       <= dividend;
                        d_r         <= magnitude(divisor);
                        q_r         <= magnitude(dividend);
                        r_r         <= {(N+1){1'b0}};
                        count_r     <= {CW{1'b0}};
                        div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                        q_neg_r     <= dividend[N-1] ^ divisor[N-1];
                        r_neg_r     <= dividend[N-1];
`endif
                        if (divisor != {N{1'b0}}) begin
                            state_r <= RUN;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    done    <= 1'b0;
                    q_r     <= q_shift_s;
                    r_r     <= ge_s ? r_sub_s : r_shift_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (count_r == CW'(N - 1)) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    quotient    <= q_res_s;
                    remainder   <= r_res_s;
                    div_by_zero <= dz_s;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
